reg_cmd_master: RTL and testbench



---
 rtl/reg_cmd_master.sv | 215 +++++++++++++++++++++
 tb/tb_reg_cmd_master.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_cmd_master.sv
// rtl/reg_cmd_master.sv - UART command-frame initiator for the register file
//
// Frames arriving on the RX byte stream are parsed and turned into register
// accesses:
//   write frame : WR_CMD, address, data -> one-cycle WrEn
//   read frame  : RD_CMD, address       -> one-cycle RdEn, read byte returned on TX
// Illegal opcodes, out-of-range addresses and bytes that arrive while an
// access is in flight are dropped and flagged with a one-cycle frame_err.
//
// Optional build macro: REG_CMD_TIMEOUT_EN
//   When defined, a 16-bit counter aborts frames stalled in WR_ADDR, WR_DATA,
//   RD_ADDR or RD_WAIT after TIMEOUT_CYCLES idle cycles (frame_err, no strobe).
//   When undefined those states wait indefinitely.
//
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   rx_data        - received byte, qualified by rx_valid
//   rx_valid       - one-cycle strobe per received byte
//   address        - register address, stable from latch until frame returns to IDLE
//   WrEn / RdEn    - one-cycle register write / read strobes (never together)
//   WrData         - register write data
//   RdData         - register read data, qualified by RdData_Valid
//   RdData_Valid   - read data valid from register file
//   tx_data        - response byte to UART TX, held after tx_valid
//   tx_valid       - one-cycle strobe, never asserted while tx_busy is high
//   tx_busy        - UART TX busy
//   frame_err      - one-cycle pulse on a dropped or illegal byte/frame
//   busy           - high whenever the frame FSM is not IDLE

module reg_cmd_master #(
    parameter int width_data    = 8,
    parameter int width_address = 4,
    parameter int num_registers = 16,
    parameter logic [width_data-1:0] WR_CMD = 8'hAA,
    parameter logic [width_data-1:0] RD_CMD = 8'hBB
`ifdef REG_CMD_TIMEOUT_EN
    ,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [width_data-1:0]    rx_data,
    input  logic                     rx_valid,
    output logic [width_address-1:0] address,
    output logic                     WrEn,
    output logic                     RdEn,
    output logic [width_data-1:0]    WrData,
    input  logic [width_data-1:0]    RdData,
    input  logic                     RdData_Valid,
    output logic [width_data-1:0]    tx_data,
    output logic                     tx_valid,
    input  logic                     tx_busy,
    output logic                     frame_err,
    output logic                     busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ADDR  = 3'd1,
        WR_DATA  = 3'd2,
        WR_ISSUE = 3'd3,
        RD_ADDR  = 3'd4,
        RD_ISSUE = 3'd5,
        RD_WAIT  = 3'd6,
        TX_SEND  = 3'd7
    } state_t;

    // One extra bit so the range compare cannot wrap for any byte value.
    localparam logic [width_data:0] reg_limit = (width_data + 1)'(num_registers);

    state_t                   state;
    state_t                   state_next;
    logic [width_address-1:0] address_q;
    logic [width_data-1:0]    wr_data_q;
    logic [width_data-1:0]    tx_data_q;
    logic                     frame_err_q;

    logic                     err_next;
    logic                     addr_latch;
    logic                     wr_latch;
    logic                     tx_latch;
    logic                     addr_illegal;
    logic                     timeout_hit;

    assign addr_illegal = ({1'b0, rx_data} >= reg_limit);

`ifdef REG_CMD_TIMEOUT_EN
    logic [15:0] timer;
    logic        timed_state;

    assign timed_state = (state == WR_ADDR) || (state == WR_DATA) ||
                         (state == RD_ADDR) || (state == RD_WAIT);

    // A byte arriving this cycle counts as activity, so it pre-empts the abort.
    assign timeout_hit = timed_state && !rx_valid && (timer == TIMEOUT_CYCLES);

    // Restart on every state change (covers entry) and every received byte.
    always_ff @(posedge clk) begin
        if (rst || !timed_state || rx_valid || (state_next != state)) begin
            timer <= '0;
        end else begin
            timer <= timer + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            address_q   <= '0;
            wr_data_q   <= '0;
            tx_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state       <= state_next;
            frame_err_q <= err_next;
            if (addr_latch) begin
                address_q <= rx_data[width_address-1:0];
            end
            if (wr_latch) begin
                wr_data_q <= rx_data;
            end
            if (tx_latch) begin
                tx_data_q <= RdData;
            end
        end
    end

    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        addr_latch = 1'b0;
        wr_latch   = 1'b0;
        tx_latch   = 1'b0;

        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == WR_CMD) begin
                        state_next = WR_ADDR;
                    end else if (rx_data == RD_CMD) begin
                        state_next = RD_ADDR;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            WR_ADDR, RD_ADDR: begin
                if (rx_valid) begin
                    if (addr_illegal) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        addr_latch = 1'b1;
                        state_next = (state == WR_ADDR) ? WR_DATA : RD_ISSUE;
                    end
                end
            end
            WR_DATA: begin
                if (rx_valid) begin
                    wr_latch   = 1'b1;
                    state_next = WR_ISSUE;
                end
            end
            WR_ISSUE: begin
                err_next   = rx_valid;
                state_next = IDLE;
            end
            RD_ISSUE: begin
                err_next   = rx_valid;
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                err_next = rx_valid;
                if (RdData_Valid) begin
                    tx_latch   = 1'b1;
                    state_next = TX_SEND;
                end
            end
            TX_SEND: begin
                err_next = rx_valid;
                if (!tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A stalled frame is abandoned without issuing any access.
        if (timeout_hit) begin
            state_next = IDLE;
            err_next   = 1'b1;
            addr_latch = 1'b0;
            wr_latch   = 1'b0;
            tx_latch   = 1'b0;
        end
    end

    // Outputs are forced low while rst is asserted, including the first
    // reset cycle before the synchronous clear has taken effect.
    assign WrEn      = !rst && (state == WR_ISSUE);
    assign RdEn      = !rst && (state == RD_ISSUE);
    assign tx_valid  = !rst && (state == TX_SEND) && !tx_busy;
    assign busy      = !rst && (state != IDLE);
    assign frame_err = !rst && frame_err_q;
    assign address   = rst ? '0 : address_q;
    assign WrData    = rst ? '0 : wr_data_q;
    assign tx_data   = rst ? '0 : tx_data_q;

endmodule

// File: tb/tb_reg_cmd_master.sv
// tb/tb_reg_cmd_master.sv - scoreboard bench for reg_cmd_master
module tb_reg_cmd_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [3:0] address;
    logic       WrEn;
    logic       RdEn;
    logic [7:0] WrData;
    logic [7:0] RdData = 8'h00;
    logic       RdData_Valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_busy = 1'b0;
    logic       frame_err;
    logic       busy;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] rd_value = 8'h00;

    localparam int K_ERR = 0;
    localparam int K_WR  = 1;
    localparam int K_RD  = 2;
    localparam int K_TX  = 3;

    typedef struct {
        int         kind;
        logic [7:0] a;
        logic [7:0] d;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];

    reg_cmd_master dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .address      (address),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .WrData       (WrData),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_busy      (tx_busy),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] a, input logic [7:0] d, input int c);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.d    = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic match(input int kind, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual=kind%0d required=none (cycle %0d)", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            if (kind == e.kind) begin
                if (kind == K_WR || kind == K_RD) chk("event_address", 32'(a), 32'(e.a));
                if (kind == K_WR || kind == K_TX) chk("event_data", 32'(d), 32'(e.d));
                if (e.cyc >= 0) chk("event_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    endtask

    // Monitor: every strobe the DUT presents is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (WrEn && RdEn) begin
                checks++;
                errors++;
                $display("FAIL strobe_overlap actual=11 required=not both (cycle %0d)", cyc);
            end
            if (tx_valid && tx_busy) begin
                checks++;
                errors++;
                $display("FAIL tx_valid_while_busy actual=1 required=0 (cycle %0d)", cyc);
            end
            if (frame_err) match(K_ERR, 8'h00, 8'h00);
            if (WrEn)      match(K_WR, {4'h0, address}, WrData);
            if (RdEn)      match(K_RD, {4'h0, address}, 8'h00);
            if (tx_valid)  match(K_TX, 8'h00, tx_data);
        end
    end

    // Register-file model: read data valid one cycle after RdEn.
    initial begin
        logic pend;
        forever begin
            @(negedge clk);
            pend = RdEn;
            @(posedge clk);
            #1;
            RdData_Valid = pend;
            RdData       = pend ? rd_value : 8'h00;
        end
    end

    task automatic send(input logic [7:0] b, output int t);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        t        = cyc;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({address, WrEn, RdEn, WrData, tx_data, tx_valid, frame_err, busy});
    endfunction

    initial begin
        int t;

        // Reset state
        rst = 1'b1;
        @(negedge clk);
        chk("reset_outputs_initial", out_vec(), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Write AA,05,3C
        send(8'hAA, t);
        send(8'h05, t);
        send(8'h3C, t);
        push(K_WR, 8'h05, 8'h3C, t + 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("busy_after_write", 32'(busy), 32'h0);

        // Read BB,02 -> RdData 81
        rd_value = 8'h81;
        send(8'hBB, t);
        send(8'h02, t);
        push(K_RD, 8'h02, 8'h00, t + 1);
        push(K_TX, 8'h00, 8'h81, t + 3);
        repeat (5) @(posedge clk);

        // Read with TX backpressure
        #1;
        tx_busy  = 1'b1;
        rd_value = 8'hC7;
        send(8'hBB, t);
        send(8'h03, t);
        push(K_RD, 8'h03, 8'h00, t + 1);
        push(K_TX, 8'h00, 8'hC7, t + 10);
        repeat (9) @(posedge clk);
        #1;
        tx_busy = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("tx_data_hold", 32'(tx_data), 32'hC7);

        // Illegal opcode
        send(8'h55, t);
        push(K_ERR, 8'h00, 8'h00, t + 1);

        // Out-of-range addresses (0x12 and boundary 0x10)
        send(8'hAA, t);
        send(8'h12, t);
        push(K_ERR, 8'h00, 8'h00, t + 1);
        send(8'hBB, t);
        send(8'h10, t);
        push(K_ERR, 8'h00, 8'h00, t + 1);

        // Highest legal address read and lowest legal address write
        rd_value = 8'h5A;
        send(8'hBB, t);
        send(8'h0F, t);
        push(K_RD, 8'h0F, 8'h00, t + 1);
        push(K_TX, 8'h00, 8'h5A, t + 3);
        repeat (4) @(posedge clk);
        send(8'hAA, t);
        send(8'h00, t);
        send(8'hFF, t);
        push(K_WR, 8'h00, 8'hFF, t + 1);
        repeat (3) @(posedge clk);

        // Reset mid-frame
        send(8'hAA, t);
        send(8'h05, t);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("reset_outputs_midframe", out_vec(), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'h3C, t);
        push(K_ERR, 8'h00, 8'h00, t + 1);
        repeat (3) @(posedge clk);

`ifdef REG_CMD_TIMEOUT_EN
        send(8'hAA, t);
        push(K_ERR, 8'h00, 8'h00, -1);
        repeat (50010) @(posedge clk);
        @(negedge clk);
        chk("busy_after_timeout", 32'(busy), 32'h0);
        send(8'hAA, t);
        send(8'h01, t);
        send(8'hFF, t);
        push(K_WR, 8'h01, 8'hFF, t + 1);
        repeat (3) @(posedge clk);
`endif

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
